sdpb_rd_arbiter: RTL
====================

Name: sdpb_rd_arbiter

Overview:
- Shares the single read port (port B) of the 8K x 16 simple-dual-port block RAM between two read clients: client 0 is the CPU data fetch and client 1 is the video/sprite fetch.
- Passes one write client (the program loader) straight through to port A.
- Sits between the clients and the SDPB instance. It issues at most one read per cycle, tags each read, and routes the returned word back to the client that issued it.

Parameters:
- AW, 13, word address width (matches the RAM depth of 8192 words).
- DW, 16, data width.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin; 1 = fixed priority with client 0 highest.

Ports:
- clk  in  1  system clock; RAM clka and clkb are tied to this clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  read request; held high with a stable address until granted.
- addr0, addr1  in  AW each  read address for each client.
- gnt0, gnt1  out  1 each  combinational grant; request accepted this cycle.
- rvalid0, rvalid1  out  1 each  read data valid for that client; one-cycle pulse.
- rdata  out  DW  returned read word, shared by both clients and qualified by rvalid0 or rvalid1.
- wr_en  in  1  loader write strobe.
- wr_addr  in  AW  loader write address.
- wr_data  in  DW  loader write data.
- ram_cea  out  1  RAM port A clock enable (write).
- ram_ada  out  AW  RAM port A address.
- ram_din  out  DW  RAM write data.
- ram_ceb  out  1  RAM port B clock enable (read).
- ram_adb  out  AW  RAM port B address.
- ram_oce  out  1  RAM output clock enable; tied to 1.
- ram_dout  in  DW  RAM read data, valid the cycle after ram_ceb (bypass read mode).

Behaviour:
- Reset (async assert, sync release) clears the following:
  - rvalid0, rvalid1 = 0.
  - rdata = 0.
  - round-robin pointer = client 0 preferred.
  - tag register = 0.
  - tag-valid register = 0.
- Reset mid-read: any in-flight return is dropped and no rvalid fires after reset releases.
- Write path is combinational passthrough:
  - ram_cea = wr_en; ram_ada = wr_addr; ram_din = wr_data.
  - Writes are never stalled.
- Read arbitration is combinational:
  - Only one request pending: grant it.
  - Both pending, PRIO_MODE = 0: grant the client the pointer prefers. On every grant the pointer moves to prefer the other client.
  - Both pending, PRIO_MODE = 1: always grant client 0. The pointer is unused.
- On any grant:
  - ram_ceb = 1 and ram_adb = the granted client's address.
  - Register tag = granted client ID and tag-valid = 1.
- No grant: ram_ceb = 0, ram_adb holds its last value, tag-valid = 0.
- Return path:
  - In the cycle after a grant, ram_dout is valid. rdata is registered from it, and rvalid[tag] pulses high the following cycle.
  - Read-to-rvalid latency is therefore 2 cycles from the gnt cycle.
  - rdata holds its last value while no rvalid is asserted.
- Throughput: back-to-back grants are allowed every cycle, so the pipeline sustains 1 read per cycle. Alternating requesters get alternating rvalids in issue order.
- A request that drops before it is granted is a protocol violation. The arbiter simply stops considering that client.
- Read and write to the same address in the same cycle (base build): the read returns the old RAM contents.

Optional Feature:
- Macro: SDPB_ARB_WRFWD_EN.
- With the macro defined:
  - When ram_ceb is issued and wr_en is high with wr_addr == ram_adb, wr_data is latched in place of ram_dout.
  - The read then returns the new data, with the same 2-cycle latency.
  - A write to the same address in the cycle between issue and return also overrides the returned word.
- Without the macro: no compare logic, and same-address reads return the pre-write data.

Test Plan:
- Reset_n low with req0 = 1: gnt0 = 0, ram_ceb = 0, rvalid0 = rvalid1 = 0, rdata = 0. After release: gnt0 = 1 in the first active cycle.
- req0 alone, addr0 = 0x0000, RAM preloaded: gnt0 in cycle N, rvalid0 = 1 in cycle N+2 with rdata = RAM[0], and rvalid1 stays 0 throughout.
- req0 and req1 held continuously, PRIO_MODE = 0, addr0 = 0x10, addr1 = 0x20: grants alternate 0,1,0,1 and rvalids alternate 2 cycles later, with the correct word each time. With PRIO_MODE = 1, gnt1 never asserts.
- Loader writes 0xBEEF to 0x1FFF, then req1 reads 0x1FFF one cycle later: rvalid1 with rdata = 0xBEEF. Also checks the top-address boundary.
- Same-cycle write 0x1234 to 0x0005 with a req0 read of 0x0005: base build returns the old value; SDPB_ARB_WRFWD_EN build returns 0x1234.
- reset_n asserted the cycle after gnt1: no rvalid1 after release, and rdata = 0.

Source files
------------

// File: rtl/sdpb_rd_arbiter_if.sv
// Bundle between the two read clients, the loader, the arbiter and the SDPB ports.
// The arbiter takes the slave modport; the clients, loader and RAM side take the master modport.
interface sdpb_rd_arbiter_if #(
   parameter int AW = 13,
   parameter int DW = 16
);
   // Read handshake: a client raises reqN with a stable addrN and holds both
   // until gntN is seen high in the same cycle. The word comes back two cycles
   // after that grant, on the one-cycle rvalidN pulse together with rdata.
   logic          req0;
   logic          req1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic          gnt0;
   logic          gnt1;
   logic          rvalid0;
   logic          rvalid1;
   logic [DW-1:0] rdata;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic          ram_cea;
   logic [AW-1:0] ram_ada;
   logic [DW-1:0] ram_din;
   logic          ram_ceb;
   logic [AW-1:0] ram_adb;
   logic          ram_oce;
   logic [DW-1:0] ram_dout;

   // Internal state, exported for observation.
   logic          dbg_rr_ptr;
   logic          dbg_tag;
   logic          dbg_tag_vld;

   modport slave (
      input  req0, req1, addr0, addr1, wr_en, wr_addr, wr_data, ram_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
      output ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce,
      output dbg_rr_ptr, dbg_tag, dbg_tag_vld
   );

   modport master (
      output req0, req1, addr0, addr1, wr_en, wr_addr, wr_data, ram_dout,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata,
      input  ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce,
      input  dbg_rr_ptr, dbg_tag, dbg_tag_vld
   );
endinterface

// File: rtl/sdpb_rd_arbiter.sv
// Two-client read arbiter and write passthrough for an 8K x 16 SDPB RAM in bypass read mode.
// Define SDPB_ARB_WRFWD_EN to forward same-address loader writes into the returned read word.
module sdpb_rd_arbiter #(
   parameter int AW        = 13,
   parameter int DW        = 16,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   sdpb_rd_arbiter_if.slave  bus
);

   logic          gnt0;
   logic          gnt1;
   logic          rr_ptr_q,  rr_ptr_d;
   logic          tag_q,     tag_d;
   logic          tag_vld_q, tag_vld_d;
   logic [AW-1:0] adb_q,     adb_d;
   logic          rvalid0_q, rvalid0_d;
   logic          rvalid1_q, rvalid1_d;
   logic [DW-1:0] rdata_q,   rdata_d;
   logic [DW-1:0] ret_word;
`ifdef SDPB_ARB_WRFWD_EN
   logic          fwd_hit_q,  fwd_hit_d;
   logic [DW-1:0] fwd_data_q, fwd_data_d;
`endif

   // Grants are held off while reset is asserted so nothing is issued into a clearing pipe.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset_n) begin
         if (bus.req0 && bus.req1) begin
            if (PRIO_MODE == 1 || !rr_ptr_q) gnt0 = 1'b1;
            else                             gnt1 = 1'b1;
         end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
         end
      end
   end

   always_comb begin
      adb_d     = adb_q;
      rr_ptr_d  = rr_ptr_q;
      tag_d     = gnt1;
      tag_vld_d = gnt0 | gnt1;
      if (gnt0) begin
         adb_d    = bus.addr0;
         rr_ptr_d = 1'b1;
      end else if (gnt1) begin
         adb_d    = bus.addr1;
         rr_ptr_d = 1'b0;
      end
   end

   // While tag_vld_q is set, adb_q still holds the address issued one cycle earlier.
   always_comb begin
      ret_word = bus.ram_dout;
`ifdef SDPB_ARB_WRFWD_EN
      if (fwd_hit_q) ret_word = fwd_data_q;
      if (bus.wr_en && (bus.wr_addr == adb_q)) ret_word = bus.wr_data;
      fwd_hit_d  = tag_vld_d && bus.wr_en && (bus.wr_addr == adb_d);
      fwd_data_d = bus.wr_data;
`endif
      rdata_d   = tag_vld_q ? ret_word : rdata_q;
      rvalid0_d = tag_vld_q & ~tag_q;
      rvalid1_d = tag_vld_q &  tag_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q   <= 1'b0;
         tag_q      <= 1'b0;
         tag_vld_q  <= 1'b0;
         adb_q      <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata_q    <= '0;
`ifdef SDPB_ARB_WRFWD_EN
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
`endif
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         tag_q      <= tag_d;
         tag_vld_q  <= tag_vld_d;
         adb_q      <= adb_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata_q    <= rdata_d;
`ifdef SDPB_ARB_WRFWD_EN
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
`endif
      end
   end

   assign bus.gnt0        = gnt0;
   assign bus.gnt1        = gnt1;
   assign bus.rvalid0     = rvalid0_q;
   assign bus.rvalid1     = rvalid1_q;
   assign bus.rdata       = rdata_q;

   assign bus.ram_cea     = bus.wr_en;
   assign bus.ram_ada     = bus.wr_addr;
   assign bus.ram_din     = bus.wr_data;
   assign bus.ram_ceb     = gnt0 | gnt1;
   assign bus.ram_adb     = adb_d;
   assign bus.ram_oce     = 1'b1;

   assign bus.dbg_rr_ptr  = rr_ptr_q;
   assign bus.dbg_tag     = tag_q;
   assign bus.dbg_tag_vld = tag_vld_q;

endmodule
